// File: rtl/apb_master_bridge_if.sv
// Request/response and APB3 signal bundle for apb_master_bridge.
// The master modport is the bridge side; the slave modport is the environment side.
interface apb_master_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: single-outstanding request/response to APB transfers,
// with address-window decode and an optional wait-state timeout.
// Ports: clk, rst (sync, active-high), bus (apb_master_bridge_if.master):
//   req_valid/req_ready/req_write/req_addr/req_wdata, rsp_valid/rsp_rdata/rsp_err,
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA/PREADY/PSLVERR in.
// Build option: define APB_TIMEOUT_EN to abort transfers stalled by PREADY.
module apb_master_bridge #(
    parameter logic [31:0] START_ADDRESS   = 32'h8c000000,
    parameter logic [31:0] END_ADDRESS     = 32'h8c000010,
    parameter int          MAX_WAIT_STATES = 32
) (
    input logic                  clk,
    input logic                  rst,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        in_window;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    assign in_window = (bus.req_addr >= START_ADDRESS) &&
                       (bus.req_addr <= END_ADDRESS) &&
                       (bus.req_addr[1:0] == 2'b00);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Next-state and latched-request logic
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
`ifdef APB_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                    if (in_window) begin
                        err_d   = 1'b0;
                        state_d = SETUP;
                    end else begin
                        // Decode error: answer without touching the bus
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.PREADY) begin
                    err_d   = bus.PSLVERR;
                    rdata_d = (!write_q && !bus.PSLVERR) ? bus.PRDATA : '0;
                    state_d = RESP;
                end
`ifdef APB_TIMEOUT_EN
                // Counter reaching MAX means this is wait cycle MAX+1
                else if (wait_cnt_q == CNT_W'(MAX_WAIT_STATES)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero outside a transfer
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.PWRITE    = 1'b0;
        bus.PADDR     = '0;
        bus.PWDATA    = '0;
        unique case (state_q)
            IDLE: bus.req_ready = !rst;
            SETUP: begin
                bus.PSEL   = 1'b1;
                bus.PWRITE = write_q;
                bus.PADDR  = addr_q;
                bus.PWDATA = wdata_q;
            end
            ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
                bus.PWRITE  = write_q;
                bus.PADDR   = addr_q;
                bus.PWDATA  = wdata_q;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_apb_master_bridge;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    apb_master_bridge_if bus ();

    apb_master_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer; PREADY rises on ACCESS cycle waits+1.
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] prd, input logic slverr,
                        output logic [31:0] rdata, output logic err,
                        output int n_acc, output int n_sel, output int lat);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = prd;
        bus.PSLVERR   = slverr;
        cyc();
        bus.req_valid = 1'b0;
        lat   = 1;
        n_acc = 0;
        n_sel = 0;
        while (!bus.rsp_valid && lat < 300) begin
            if (bus.PSEL) n_sel++;
            if (bus.PSEL && bus.PENABLE) n_acc++;
            bus.PREADY = bus.PSEL && bus.PENABLE && (n_acc == waits + 1);
            cyc();
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        chk("rsp_psel_low", {31'b0, bus.PSEL}, 32'd0);
        bus.PREADY = 1'b0;
        cyc();
        chk("rsp_one_cycle", {31'b0, bus.rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          na, ns, lt;

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        cyc();
        cyc();
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("reset_psel", {31'b0, bus.PSEL}, 32'd0);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_paddr", bus.PADDR, 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_reset_ready", {31'b0, bus.req_ready}, 32'd1);

        // Zero-wait write, cycle by cycle
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h8c000004;
        bus.req_wdata = 32'hDEADBEEF;
        bus.PREADY    = 1'b1;
        cyc();
        bus.req_valid = 1'b0;
        chk("setup_psel", {31'b0, bus.PSEL}, 32'd1);
        chk("setup_penable", {31'b0, bus.PENABLE}, 32'd0);
        chk("setup_paddr", bus.PADDR, 32'h8c000004);
        chk("setup_pwdata", bus.PWDATA, 32'hDEADBEEF);
        chk("setup_pwrite", {31'b0, bus.PWRITE}, 32'd1);
        chk("setup_ready", {31'b0, bus.req_ready}, 32'd0);
        cyc();
        chk("access_penable", {31'b0, bus.PENABLE}, 32'd1);
        chk("access_paddr", bus.PADDR, 32'h8c000004);
        chk("access_pwdata", bus.PWDATA, 32'hDEADBEEF);
        cyc();
        bus.PREADY = 1'b0;
        chk("wr_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("wr_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("wr_psel_off", {31'b0, bus.PSEL}, 32'd0);
        chk("wr_paddr_off", bus.PADDR, 32'd0);
        cyc();
        chk("wr_rsp_drop", {31'b0, bus.rsp_valid}, 32'd0);
        chk("wr_ready_back", {31'b0, bus.req_ready}, 32'd1);

        // Read at END_ADDRESS with 3 wait states
        xfer(1'b0, 32'h8c000010, 32'h0, 3, 32'h12345678, 1'b0,
             rd, er, na, ns, lt);
        chk("rd3_access", na, 32'd4);
        chk("rd3_latency", lt, 32'd6);
        chk("rd3_rdata", rd, 32'h12345678);
        chk("rd3_err", {31'b0, er}, 32'd0);

        // Decode errors: above window, below window, misaligned
        xfer(1'b0, 32'h8c000014, 32'h0, 0, 32'hAAAAAAAA, 1'b0,
             rd, er, na, ns, lt);
        chk("dec_hi_sel", ns, 32'd0);
        chk("dec_hi_lat", lt, 32'd1);
        chk("dec_hi_err", {31'b0, er}, 32'd1);
        chk("dec_hi_rdata", rd, 32'd0);
        xfer(1'b0, 32'h8bffff00, 32'h0, 0, 32'hAAAAAAAA, 1'b0,
             rd, er, na, ns, lt);
        chk("dec_lo_sel", ns, 32'd0);
        chk("dec_lo_lat", lt, 32'd1);
        chk("dec_lo_err", {31'b0, er}, 32'd1);
        xfer(1'b0, 32'h8c000002, 32'h0, 0, 32'hAAAAAAAA, 1'b0,
             rd, er, na, ns, lt);
        chk("dec_mis_sel", ns, 32'd0);
        chk("dec_mis_lat", lt, 32'd1);
        chk("dec_mis_err", {31'b0, er}, 32'd1);
        xfer(1'b0, 32'h8bfffffc, 32'h0, 0, 32'hAAAAAAAA, 1'b0,
             rd, er, na, ns, lt);
        chk("dec_start_m4", {31'b0, er}, 32'd1);

        // Write at START_ADDRESS; read data bus is ignored for writes
        xfer(1'b1, 32'h8c000000, 32'h01020304, 1, 32'hFFFFFFFF, 1'b0,
             rd, er, na, ns, lt);
        chk("wr_start_err", {31'b0, er}, 32'd0);
        chk("wr_start_rdata", rd, 32'd0);
        chk("wr_start_acc", na, 32'd2);

        // Slave error on a read
        xfer(1'b0, 32'h8c00000c, 32'h0, 0, 32'hCAFEF00D, 1'b1,
             rd, er, na, ns, lt);
        chk("slverr_err", {31'b0, er}, 32'd1);
        chk("slverr_rdata", rd, 32'd0);
        chk("slverr_lat", lt, 32'd3);

`ifdef APB_TIMEOUT_EN
        xfer(1'b0, 32'h8c000008, 32'h0, 1000, 32'h55555555, 1'b0,
             rd, er, na, ns, lt);
        chk("tmo_access", na, 32'd33);
        chk("tmo_err", {31'b0, er}, 32'd1);
        chk("tmo_rdata", rd, 32'd0);
        chk("tmo_lat", lt, 32'd35);
        xfer(1'b0, 32'h8c000008, 32'h0, 32, 32'h55555555, 1'b0,
             rd, er, na, ns, lt);
        chk("tmo_edge_access", na, 32'd33);
        chk("tmo_edge_err", {31'b0, er}, 32'd0);
        chk("tmo_edge_rdata", rd, 32'h55555555);
`else
        xfer(1'b0, 32'h8c000008, 32'h0, 40, 32'h55555555, 1'b0,
             rd, er, na, ns, lt);
        chk("long_wait_access", na, 32'd41);
        chk("long_wait_err", {31'b0, er}, 32'd0);
        chk("long_wait_rdata", rd, 32'h55555555);
`endif

        // Reset during ACCESS
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h8c000004;
        bus.PREADY    = 1'b0;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        chk("mid_access", {31'b0, bus.PENABLE}, 32'd1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_psel", {31'b0, bus.PSEL}, 32'd0);
        chk("mid_rst_penable", {31'b0, bus.PENABLE}, 32'd0);
        chk("mid_rst_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_rsp2", {31'b0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        xfer(1'b0, 32'h8c000004, 32'h0, 0, 32'h0BADC0DE, 1'b0,
             rd, er, na, ns, lt);
        chk("post_rst_rdata", rd, 32'h0BADC0DE);
        chk("post_rst_lat", lt, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB3 master bridge that converts a simple single-outstanding request/response interface into APB transfers towards the audioport DUT. It sits directly upstream of the DUT's APB slave port. It decodes the DUT address window and rejects addresses outside it without touching the bus. It also bounds slave wait states so a hung slave cannot stall the controller.

## Interface
- `START_ADDRESS`, default `32'h8c000000`: first byte address of the DUT window (inclusive).
- `END_ADDRESS`, default `32'h8c000010`: last byte address of the DUT window (inclusive).
- `MAX_WAIT_STATES`, default `32`: number of PREADY-low ACCESS cycles tolerated before a transfer is aborted.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic samples on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  read data (0 for writes and for errors).
- `rsp_err`  out  1  error flag: PSLVERR, decode error or timeout.
- `PSEL`, `PENABLE`, `PWRITE`  out  1 each  APB control.
- `PADDR`, `PWDATA`  out  32 each  APB address and write data.
- `PRDATA`  in  32  APB read data.
- `PREADY`, `PSLVERR`  in  1 each  APB slave handshake.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready=1`.
  - A request is accepted when `req_valid && req_ready`.
  - Accepted request that is in-window and word-aligned (`addr[1:0]==0`): go to SETUP.
  - Any other accepted request: go directly to RESP with `rsp_err=1` and no APB activity.
- SETUP:
  - `PSEL=1`, `PENABLE=0`.
  - PADDR, PWRITE and PWDATA carry the latched request.
  - Next state is always ACCESS.
- ACCESS:
  - `PSEL=1`, `PENABLE=1`; address and data are held stable.
  - `PREADY=1`: latch `PRDATA` (reads only) and `PSLVERR`, then go to RESP.
  - `PREADY=0`: increment the wait counter (width `$clog2(MAX_WAIT_STATES+1)`).
- RESP:
  - `rsp_valid=1` for exactly one cycle.
  - `rsp_err` = latched PSLVERR, decode error, or timeout.
  - `rsp_rdata` = latched PRDATA for a successful read, otherwise 0.
  - Next state is IDLE.
  - The response has no backpressure.
- APB outputs outside SETUP/ACCESS: PSEL, PENABLE, PWRITE, PADDR and PWDATA are all 0.
- Wait counter is cleared on entry to SETUP.
- Only one transaction is outstanding; `req_ready=0` in SETUP, ACCESS and RESP.

## Timing
- Reset values: `req_ready=0` while `rst=1`, then 1 from the first cycle after reset; all other outputs 0; state IDLE.
- Zero-wait transfer: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2 (PREADY=1), `rsp_valid` at cycle 3, `req_ready=1` at cycle 4.
- Each wait state adds one ACCESS cycle.
- Decode error: accept at cycle 0, `rsp_valid` at cycle 1.
- Window boundaries: `END_ADDRESS` itself is in-window; `END_ADDRESS+4` and `START_ADDRESS-4` are decode errors.
- Reset mid-transfer: PSEL and PENABLE are 0 from the edge after `rst` is sampled, no `rsp_valid` is produced, and the FSM returns to IDLE.
- PREADY is ignored outside ACCESS.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - Up to MAX_WAIT_STATES ACCESS cycles with PREADY low are tolerated.
  - If PREADY is still low on ACCESS cycle MAX_WAIT_STATES+1, the transfer aborts.
  - On abort, PSEL and PENABLE drop next cycle and the FSM enters RESP with `rsp_err=1`, `rsp_rdata=0`.
  - PREADY=1 on that same cycle completes the transfer normally.
- `APB_TIMEOUT_EN` undefined:
  - No timeout; ACCESS holds until PREADY=1.
  - The wait counter logic is compiled out.

## Test plan
- Write 0x8c000004 data 0xDEADBEEF, PREADY=1 immediately -> SETUP/ACCESS on cycles 1/2 with PADDR=0x8c000004, PWDATA=0xDEADBEEF, PWRITE=1; `rsp_valid` on cycle 3 with `rsp_err=0`.
- Read 0x8c000010, PRDATA=0x12345678, 3 wait states -> ACCESS lasts 4 cycles; `rsp_rdata=0x12345678` with `rsp_err=0`.
- Read 0x8c000014, then 0x8bffff00, then 0x8c000002 -> no PSEL for any of them; each gives `rsp_valid` one cycle after acceptance with `rsp_err=1`.
- PSLVERR=1 with PREADY=1 on a read -> `rsp_err=1`, `rsp_rdata=0`.
- With `APB_TIMEOUT_EN` defined: PREADY held low -> abort after 33 ACCESS cycles with `rsp_err=1`. A second run with PREADY rising on ACCESS cycle 33 -> success.
- Assert `rst` during ACCESS -> next cycle PSEL=0, PENABLE=0, `rsp_valid=0`; a new request is accepted after reset is released.
